leitor_registradores: RTL and testbench
=======================================

Name: leitor_registradores

Overview:
Operand-fetch sequencer on the read side of the register bank. The bank's 16-bit registers are loaded through their enable/clock/input port. This block reads them back by driving one-hot output-enable selects onto the shared bus and capturing the bus value. It serves the control unit, which issues a start with up to two register indexes and receives latched operands plus a one-cycle done pulse.

Parameters:
DATA_WIDTH, 16, width of bus and operands
NUM_REGS, 8, registers in the bank (one-hot select width)
SEL_WIDTH, 3, index width, equal to clog2(NUM_REGS)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
rx_sel  input  SEL_WIDTH  index of first operand register
ry_sel  input  SEL_WIDTH  index of second operand register
two_operands  input  1  1 = fetch rx then ry; 0 = fetch rx only
bus_in  input  DATA_WIDTH  shared bus value driven by the selected register
read_sel  output  NUM_REGS  one-hot register output enable (all-zero when not reading)
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when operands are valid
operand_a  output  DATA_WIDTH  captured rx value
operand_b  output  DATA_WIDTH  captured ry value

Behaviour:
- Single clock. Reset is synchronous, active-high, and named "reset". The clock is named "clock".
- Reset (at any time, including mid-fetch): state=IDLE, read_sel=0, busy=0, done=0, operand_a=0, operand_b=0.
- States: IDLE, READ_A, READ_B, DONE.
- IDLE: start=1 latches rx_sel, ry_sel and two_operands into internal registers and moves to READ_A. Selects are not re-sampled later.
- READ_A: read_sel=onehot(rx). operand_a<=bus_in at the edge leaving READ_A. Next state is READ_B if two_operands=1, else DONE.
- READ_B: read_sel=onehot(ry). operand_b<=bus_in at the edge leaving READ_B. Next state is DONE.
- DONE: read_sel=0, done=1 for exactly this cycle. Next state is IDLE. operand_b is unchanged when only one operand was fetched.
- read_sel is registered and glitch-free. At most one bit is ever high. It is never high in IDLE or DONE.
- Latency: start sampled at edge k gives done high during cycle k+3 (two operands) or k+2 (one operand).
- start while busy: ignored, no queuing. The next start is accepted only in IDLE, i.e. the cycle after done, so the minimum issue interval is 4 cycles for two operands and 3 for one.
- rx_sel==ry_sel without the optional feature: both reads are performed, and A and B capture the bus independently.
- Operands hold their values until the next capture or reset.

Optional Feature:
Macro LEITOR_MESMO_REG_EN.
- Defined: if two_operands=1 and the latched rx==ry, skip READ_B. operand_b<=bus_in at the same edge as operand_a, and READ_A goes straight to DONE. Latency becomes k+2.
- Undefined: no comparison is made, and the behaviour is exactly as in Behaviour.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> read_sel=0, busy=0, done=0, operand_a=operand_b=16'h0000.
- Two-operand fetch: bank r2=16'h56ab, r5=16'h0bff; start with rx=2, ry=5, two=1 -> read_sel=8'b00000100 then 8'b00100000; done in cycle k+3 with operand_a=16'h56ab, operand_b=16'h0bff.
- One-operand fetch: r7=16'h98a3; start with rx=7, two=0 -> read_sel=8'b10000000 for one cycle; done at k+2; operand_a=16'h98a3; operand_b keeps its previous value 16'h0bff.
- start held high for 6 cycles -> exactly one fetch per IDLE visit; done pulses are 4 cycles apart; read_sel is never multi-hot.
- Reset mid-fetch: assert reset during READ_B -> next cycle all outputs are 0, and no done pulse occurs; a following start (rx=0, r0=16'h5555) completes normally.
- Same register (rx=ry=3, r3=16'h1234): without the macro, done at k+3 with both operands=16'h1234; with LEITOR_MESMO_REG_EN, done at k+2 and read_sel is asserted for one cycle only.

Source files
------------

// File: rtl/leitor_registradores.sv
// Operand-fetch sequencer: reads one or two bank registers over the shared bus via one-hot output enables.
// Optional macro LEITOR_MESMO_REG_EN: a two-operand fetch with rx==ry reads the bus once for both operands.
module leitor_registradores #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned SEL_WIDTH  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SEL_WIDTH-1:0]  rx_sel,
  input  logic [SEL_WIDTH-1:0]  ry_sel,
  input  logic                  two_operands,
  input  logic [DATA_WIDTH-1:0] bus_in,
  output logic [NUM_REGS-1:0]   read_sel,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] operand_a,
  output logic [DATA_WIDTH-1:0] operand_b
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ_A = 2'd1,
    ST_READ_B = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [SEL_WIDTH-1:0]  rx_q, rx_d;
  logic [SEL_WIDTH-1:0]  ry_q, ry_d;
  logic                  two_q, two_d;
  logic [NUM_REGS-1:0]   read_sel_q, read_sel_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] operand_a_q, operand_a_d;
  logic [DATA_WIDTH-1:0] operand_b_q, operand_b_d;
  logic                  same_reg_c;

`ifdef LEITOR_MESMO_REG_EN
  assign same_reg_c = two_q && (rx_q == ry_q);
`else
  assign same_reg_c = 1'b0;
`endif

  // Next state, captures, and registered outputs derived from the next state
  always_comb begin
    state_d     = state_q;
    rx_d        = rx_q;
    ry_d        = ry_q;
    two_d       = two_q;
    operand_a_d = operand_a_q;
    operand_b_d = operand_b_q;
    read_sel_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rx_d    = rx_sel;
          ry_d    = ry_sel;
          two_d   = two_operands;
          state_d = ST_READ_A;
        end
      end
      ST_READ_A: begin
        operand_a_d = bus_in;
        if (same_reg_c) begin
          operand_b_d = bus_in;
          state_d     = ST_DONE;
        end else if (two_q) begin
          state_d = ST_READ_B;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_READ_B: begin
        operand_b_d = bus_in;
        state_d     = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Enables lead the state by being computed from it, so they are flop outputs
    case (state_d)
      ST_READ_A: read_sel_d = NUM_REGS'(1) << rx_d;
      ST_READ_B: read_sel_d = NUM_REGS'(1) << ry_d;
      default:   read_sel_d = '0;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rx_q        <= '0;
      ry_q        <= '0;
      two_q       <= 1'b0;
      read_sel_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      operand_a_q <= '0;
      operand_b_q <= '0;
    end else begin
      state_q     <= state_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      two_q       <= two_d;
      read_sel_q  <= read_sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      operand_a_q <= operand_a_d;
      operand_b_q <= operand_b_d;
    end
  end

  assign read_sel  = read_sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign operand_a = operand_a_q;
  assign operand_b = operand_b_q;

endmodule

// File: tb/tb_leitor_registradores.sv
// Self-checking bench for leitor_registradores with a behavioural register bank on the shared bus.
module tb_leitor_registradores;

  localparam int unsigned DW = 16;
  localparam int unsigned NR = 8;
  localparam int unsigned SW = 3;
`ifdef LEITOR_MESMO_REG_EN
  localparam bit SAME_EN = 1'b1;
`else
  localparam bit SAME_EN = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          start;
  logic [SW-1:0] rx_sel;
  logic [SW-1:0] ry_sel;
  logic          two_operands;
  logic [DW-1:0] bus_in;
  logic [NR-1:0] read_sel;
  logic          busy;
  logic          done;
  logic [DW-1:0] operand_a;
  logic [DW-1:0] operand_b;

  logic [DW-1:0] bank [NR];
  logic [DW-1:0] exp_a;
  logic [DW-1:0] exp_b;
  int            n_checks;
  int            n_fail;

  leitor_registradores #(.DATA_WIDTH(DW), .NUM_REGS(NR), .SEL_WIDTH(SW)) dut (
    .clock(clock), .reset(reset), .start(start), .rx_sel(rx_sel), .ry_sel(ry_sel),
    .two_operands(two_operands), .bus_in(bus_in), .read_sel(read_sel), .busy(busy),
    .done(done), .operand_a(operand_a), .operand_b(operand_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bank model: every enabled register drives the bus (wired-OR)
  always_comb begin
    bus_in = '0;
    for (int i = 0; i < NR; i++)
      if (read_sel[i]) bus_in = bus_in | bank[i];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_read_sel"}, 32'(read_sel), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
  endtask

  // One complete fetch; inputs are scrambled after start to prove they are latched
  task automatic do_fetch(input logic [SW-1:0] rx, input logic [SW-1:0] ry, input logic two);
    int           n_reads;
    logic [SW-1:0] idx;
    start = 1'b1; rx_sel = rx; ry_sel = ry; two_operands = two;
    tick();
    start = 1'b0;
    rx_sel = SW'($urandom); ry_sel = SW'($urandom); two_operands = 1'($urandom);
    n_reads = (two && !(SAME_EN && rx == ry)) ? 2 : 1;
    for (int i = 0; i < n_reads; i++) begin
      idx = (i == 0) ? rx : ry;
      chk("fetch_read_sel", 32'(read_sel), 32'(1) << idx);
      chk("fetch_busy", 32'(busy), 32'(1));
      chk("fetch_done_early", 32'(done), 32'(0));
      tick();
    end
    exp_a = bank[rx];
    if (two) exp_b = bank[ry];
    chk("done_pulse", 32'(done), 32'(1));
    chk("done_read_sel", 32'(read_sel), 32'(0));
    chk("done_busy", 32'(busy), 32'(1));
    chk("operand_a", 32'(operand_a), 32'(exp_a));
    chk("operand_b", 32'(operand_b), 32'(exp_b));
    tick();
    chk_idle_zero("after_done");
    chk("hold_a", 32'(operand_a), 32'(exp_a));
    chk("hold_b", 32'(operand_b), 32'(exp_b));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int done_cnt;
    n_checks = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; rx_sel = '0; ry_sel = '0; two_operands = 1'b0;
    for (int i = 0; i < NR; i++) bank[i] = DW'($urandom);
    exp_a = '0; exp_b = '0;

    // Reset then idle
    tick(); tick();
    reset = 1'b0;
    chk_idle_zero("reset");
    chk("reset_a", 32'(operand_a), 32'(0));
    chk("reset_b", 32'(operand_b), 32'(0));
    tick();
    chk_idle_zero("idle");

    // Directed two-operand and one-operand fetches
    bank[2] = 16'h56ab; bank[5] = 16'h0bff; bank[7] = 16'h98a3;
    do_fetch(3'd2, 3'd5, 1'b1);
    chk("dir_a", 32'(operand_a), 32'h56ab);
    chk("dir_b", 32'(operand_b), 32'h0bff);
    do_fetch(3'd7, 3'd1, 1'b0);
    chk("one_a", 32'(operand_a), 32'h98a3);
    chk("one_b_kept", 32'(operand_b), 32'h0bff);

    // start held for 6 edges: accepted only at edges 1 and 5, done after edges 3 and 7
    start = 1'b1; rx_sel = 3'd1; ry_sel = 3'd4; two_operands = 1'b1;
    done_cnt = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 6) start = 1'b0;
      chk("hold_onehot0", 32'($onehot0(read_sel)), 32'(1));
      chk("hold_done", 32'(done), 32'((n == 3) || (n == 7)));
      if (done) done_cnt++;
    end
    chk("hold_done_count", 32'(done_cnt), 32'(2));
    exp_a = bank[1]; exp_b = bank[4];
    chk("hold_a", 32'(operand_a), 32'(exp_a));
    chk("hold_b", 32'(operand_b), 32'(exp_b));

    // Reset asserted during READ_B
    start = 1'b1; rx_sel = 3'd1; ry_sel = 3'd6; two_operands = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("midrst_in_read_b", 32'(read_sel), 32'(1) << 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle_zero("midrst");
    chk("midrst_a", 32'(operand_a), 32'(0));
    chk("midrst_b", 32'(operand_b), 32'(0));
    exp_a = '0; exp_b = '0;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("midrst_no_done", 32'(done), 32'(0));
      chk("midrst_idle_busy", 32'(busy), 32'(0));
    end
    bank[0] = 16'h5555;
    do_fetch(3'd0, 3'd0, 1'b0);
    chk("post_rst_a", 32'(operand_a), 32'h5555);
    chk("post_rst_b", 32'(operand_b), 32'h0000);

    // Same register for both operands
    bank[3] = 16'h1234;
    do_fetch(3'd3, 3'd3, 1'b1);
    chk("same_a", 32'(operand_a), 32'h1234);
    chk("same_b", 32'(operand_b), 32'h1234);

    // Randomized fetches against the bank model
    for (int t = 0; t < 40; t++) begin
      logic [SW-1:0] rx, ry;
      for (int i = 0; i < NR; i++) bank[i] = DW'($urandom);
      rx = SW'($urandom);
      ry = ($urandom_range(0, 3) == 0) ? rx : SW'($urandom);
      do_fetch(rx, ry, 1'($urandom));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        tick();
        chk_idle_zero("gap");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
